// File: rtl/uart_tx.sv
// 8N1 UART transmitter: serialises a captured byte LSB first, paced by the
// shared oversampling baud tick, with busy and one-cycle done reporting.
module uart_tx #(
    parameter int unsigned NB_DATA    = 8,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned SB_TICK    = 16
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_tick,
    input  logic               i_tx_start,
    input  logic [NB_DATA-1:0] i_tx_data,
    output logic               o_tx,
    output logic               o_tx_busy,
    output logic               o_tx_done
);

    localparam int unsigned S_MAX = (OVERSAMPLE > SB_TICK) ? OVERSAMPLE : SB_TICK;
    localparam int unsigned S_W   = (S_MAX > 1) ? $clog2(S_MAX) : 1;
    localparam int unsigned N_W   = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;

    localparam logic [S_W-1:0] OS_LAST = S_W'(OVERSAMPLE - 1);
    localparam logic [S_W-1:0] SB_LAST = S_W'(SB_TICK - 1);
    localparam logic [N_W-1:0] N_LAST  = N_W'(NB_DATA - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t             state,  state_next;
    logic [S_W-1:0]     s_cnt,  s_cnt_next;
    logic [N_W-1:0]     n_cnt,  n_cnt_next;
    logic [NB_DATA-1:0] shreg,  shreg_next;
    logic               tx_next;
    logic               busy_next;
    logic               done_next;

    // State and output registers; outputs are loaded from next-state values
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state     <= IDLE;
            s_cnt     <= '0;
            n_cnt     <= '0;
            shreg     <= '0;
            o_tx      <= 1'b1;
            o_tx_busy <= 1'b0;
            o_tx_done <= 1'b0;
        end else begin
            state     <= state_next;
            s_cnt     <= s_cnt_next;
            n_cnt     <= n_cnt_next;
            shreg     <= shreg_next;
            o_tx      <= tx_next;
            o_tx_busy <= busy_next;
            o_tx_done <= done_next;
        end
    end

    // Next-state and datapath; without a tick everything holds
    always_comb begin
        state_next = state;
        s_cnt_next = s_cnt;
        n_cnt_next = n_cnt;
        shreg_next = shreg;
        done_next  = 1'b0;

        case (state)
            IDLE: begin
                // A tick coinciding with acceptance is deliberately not counted
                if (i_tx_start) begin
                    shreg_next = i_tx_data;
                    s_cnt_next = '0;
                    state_next = START;
                end
            end
            START: begin
                if (i_tick) begin
                    if (s_cnt == OS_LAST) begin
                        s_cnt_next = '0;
                        n_cnt_next = '0;
                        state_next = DATA;
                    end else begin
                        s_cnt_next = s_cnt + S_W'(1);
                    end
                end
            end
            DATA: begin
                if (i_tick) begin
                    if (s_cnt == OS_LAST) begin
                        s_cnt_next = '0;
                        shreg_next = shreg >> 1;
                        if (n_cnt == N_LAST) begin
                            state_next = STOP;
                        end else begin
                            n_cnt_next = n_cnt + N_W'(1);
                        end
                    end else begin
                        s_cnt_next = s_cnt + S_W'(1);
                    end
                end
            end
            STOP: begin
                if (i_tick) begin
                    if (s_cnt == SB_LAST) begin
                        s_cnt_next = '0;
                        state_next = IDLE;
                        done_next  = 1'b1;
                    end else begin
                        s_cnt_next = s_cnt + S_W'(1);
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = shreg_next[0];
            default: tx_next = 1'b1;
        endcase

        busy_next = (state_next != IDLE);
    end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: table of frames checked bit-by-bit, plus
// reset, mid-frame start, abort and back-to-back (2 stop bit) sequences.
module tb_uart_tx;

    logic       i_clock = 1'b0;
    logic       i_reset;
    logic       i_tick;
    logic       i_tx_start;
    logic [7:0] i_tx_data;
    logic       o_tx;
    logic       o_tx_busy;
    logic       o_tx_done;

    logic       tick2;
    logic       start2;
    logic [7:0] data2;
    logic       tx2;
    logic       busy2;
    logic       done2;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 i_clock = ~i_clock;

    uart_tx #(.NB_DATA(8), .OVERSAMPLE(16), .SB_TICK(16)) dut (
        .i_clock    (i_clock),
        .i_reset    (i_reset),
        .i_tick     (i_tick),
        .i_tx_start (i_tx_start),
        .i_tx_data  (i_tx_data),
        .o_tx       (o_tx),
        .o_tx_busy  (o_tx_busy),
        .o_tx_done  (o_tx_done)
    );

    uart_tx #(.NB_DATA(8), .OVERSAMPLE(16), .SB_TICK(32)) dut2 (
        .i_clock    (i_clock),
        .i_reset    (i_reset),
        .i_tick     (tick2),
        .i_tx_start (start2),
        .i_tx_data  (data2),
        .o_tx       (tx2),
        .o_tx_busy  (busy2),
        .o_tx_done  (done2)
    );

    typedef struct {
        logic [7:0]  data;
        int unsigned div;     // tick every div cycles
        logic [9:0]  frame;   // expected line levels, bit 0 = start bit
        int unsigned inject;  // cycle to pulse a stray start with 0xFF, 0 = none
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge i_clock);
        #1;
    endtask

    // Accepts a frame on a tick cycle, then samples every cycle of the frame.
    task automatic send_frame(input logic [7:0] data, input int unsigned div,
                              input logic [9:0] frame, input int unsigned inject,
                              input string tag);
        int unsigned len;
        int unsigned bitlen;
        int unsigned idx;
        int          bit_bad[10];
        int          busy_cnt;
        int          done_cnt;
        int unsigned done_at;
        int          tail_bad;
        logic [7:0]  dec;

        len      = 160 * div;
        bitlen   = 16 * div;
        busy_cnt = 0;
        done_cnt = 0;
        done_at  = 0;
        tail_bad = 0;
        dec      = 8'h00;
        for (int i = 0; i < 10; i++) bit_bad[i] = 0;

        i_tx_start = 1'b1;
        i_tx_data  = data;
        i_tick     = 1'b1;
        cyc();
        i_tx_start = 1'b0;
        i_tx_data  = ~data;

        for (int unsigned k = 1; k <= len + 2; k++) begin
            if (k <= len) begin
                idx = (k - 1) / bitlen;
                if (o_tx !== frame[idx]) bit_bad[idx]++;
                if (((k - 1) % bitlen) == bitlen / 2 && idx >= 1 && idx <= 8)
                    dec[idx-1] = o_tx;
            end else if (o_tx !== 1'b1) begin
                tail_bad++;
            end
            if (o_tx_busy === 1'b1) busy_cnt++;
            if (o_tx_done === 1'b1) begin
                done_cnt++;
                done_at = k;
            end
            i_tx_start = (k == inject);
            if (k == inject) i_tx_data = 8'hFF;
            i_tick = ((k % div) == 0);
            cyc();
        end
        i_tx_start = 1'b0;
        i_tick     = 1'b0;

        for (int i = 0; i < 10; i++)
            check($sformatf("%s line bit%0d", tag, i), 32'(bit_bad[i]), 32'd0);
        check({tag, " decoded byte"}, 32'(dec), 32'(data));
        check({tag, " busy cycles"}, 32'(busy_cnt), 32'(len));
        check({tag, " done count"}, 32'(done_cnt), 32'd1);
        check({tag, " done cycle"}, done_at, len + 1);
        check({tag, " idle after"}, 32'(tail_bad), 32'd0);
    endtask

    initial begin
        vecs[0] = '{data: 8'h55, div: 1, frame: 10'b1_0101_0101_0, inject: 0};
        vecs[1] = '{data: 8'hA3, div: 4, frame: 10'b1_1010_0011_0, inject: 0};
        vecs[2] = '{data: 8'h0F, div: 1, frame: 10'b1_0000_1111_0, inject: 88};
        vecs[3] = '{data: 8'hFF, div: 2, frame: 10'b1_1111_1111_0, inject: 0};
        vecs[4] = '{data: 8'h00, div: 3, frame: 10'b1_0000_0000_0, inject: 0};

        i_reset    = 1'b1;
        i_tick     = 1'b1;
        i_tx_start = 1'b0;
        i_tx_data  = 8'h00;
        tick2      = 1'b0;
        start2     = 1'b0;
        data2      = 8'h00;

        // Reset, then idle with ticks running
        cyc();
        cyc();
        check("reset tx", 32'(o_tx), 32'd1);
        check("reset busy", 32'(o_tx_busy), 32'd0);
        check("reset done", 32'(o_tx_done), 32'd0);
        i_reset = 1'b0;
        begin
            int bad;
            bad = 0;
            for (int k = 0; k < 50; k++) begin
                cyc();
                if (o_tx !== 1'b1 || o_tx_busy !== 1'b0 || o_tx_done !== 1'b0) bad++;
            end
            check("idle outputs", 32'(bad), 32'd0);
        end
        i_tick = 1'b0;
        cyc();

        foreach (vecs[v])
            send_frame(vecs[v].data, vecs[v].div, vecs[v].frame, vecs[v].inject,
                       $sformatf("vec%0d", v));

        // Abort in data bit 3 of 0x00, then a clean 0x81
        begin
            int bad;
            int dcnt;
            i_tx_start = 1'b1;
            i_tx_data  = 8'h00;
            i_tick     = 1'b1;
            cyc();
            i_tx_start = 1'b0;
            for (int k = 1; k <= 70; k++) cyc();
            check("abort pre tx", 32'(o_tx), 32'd0);
            check("abort pre busy", 32'(o_tx_busy), 32'd1);
            i_reset = 1'b1;
            cyc();
            check("abort tx", 32'(o_tx), 32'd1);
            check("abort busy", 32'(o_tx_busy), 32'd0);
            check("abort done", 32'(o_tx_done), 32'd0);
            i_reset = 1'b0;
            bad  = 0;
            dcnt = 0;
            for (int k = 0; k < 200; k++) begin
                cyc();
                if (o_tx !== 1'b1 || o_tx_busy !== 1'b0) bad++;
                if (o_tx_done === 1'b1) dcnt++;
            end
            check("abort stays idle", 32'(bad), 32'd0);
            check("abort no done", 32'(dcnt), 32'd0);
            i_tick = 1'b0;
        end
        send_frame(8'h81, 1, 10'b1_1000_0001_0, 0, "after abort");

        // Start held high on the two-stop-bit instance: back-to-back frames
        begin
            logic [9:0]  frame;
            int          tx_bad;
            int          busy_bad;
            int          done_bad;
            int          dcnt;
            int          p;
            int          idx;
            logic        e_tx;
            logic        e_busy;
            logic        e_done;
            logic        tx_at_178;

            frame     = 10'b1_0011_1100_0;
            tx_bad    = 0;
            busy_bad  = 0;
            done_bad  = 0;
            dcnt      = 0;
            tx_at_178 = 1'b1;
            start2    = 1'b1;
            data2     = 8'h3C;
            tick2     = 1'b1;
            cyc();
            for (int k = 1; k <= 356; k++) begin
                if (k <= 176)      p = k - 1;
                else if (k >= 178 && k <= 353) p = k - 178;
                else               p = -1;
                if (p >= 0) begin
                    idx    = (p < 160) ? p / 16 : 9;
                    e_tx   = frame[idx];
                    e_busy = 1'b1;
                end else begin
                    e_tx   = 1'b1;
                    e_busy = 1'b0;
                end
                e_done = (k == 177 || k == 354);
                if (tx2 !== e_tx) tx_bad++;
                if (busy2 !== e_busy) busy_bad++;
                if (done2 !== e_done) done_bad++;
                if (done2 === 1'b1) dcnt++;
                if (k == 178) tx_at_178 = tx2;
                if (k == 200) start2 = 1'b0;
                cyc();
            end
            tick2 = 1'b0;
            check("b2b line", 32'(tx_bad), 32'd0);
            check("b2b busy", 32'(busy_bad), 32'd0);
            check("b2b done timing", 32'(done_bad), 32'd0);
            check("b2b done count", 32'(dcnt), 32'd2);
            check("b2b second start bit", 32'(tx_at_178), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
Serial UART transmitter that returns ALU results to the host, completing the RX -> interface -> ALU -> TX loop. It accepts a parallel byte and a start strobe from the interface FSM (its result byte and tx-signal outputs). It serialises the byte as 8N1, LSB first, paced by the shared oversampling baud tick. It reports busy and a one-cycle completion pulse.

Parameters:
NB_DATA, 8, data bits per frame
OVERSAMPLE, 16, baud ticks per start/data bit
SB_TICK, 16, baud ticks for the stop bit (16 = 1 stop bit, 24 = 1.5, 32 = 2)

Ports:
i_clock  in  1  system clock, all logic on rising edge
i_reset  in  1  synchronous, active-high reset
i_tick  in  1  baud-rate-generator strobe, one cycle wide, OVERSAMPLE per bit period
i_tx_start  in  1  request to send i_tx_data; sampled only in IDLE
i_tx_data  in  NB_DATA  byte to send; captured on the accepted start cycle
o_tx  out  1  serial line, idle high, registered
o_tx_busy  out  1  high from the cycle after acceptance until return to IDLE
o_tx_done  out  1  one-cycle pulse when the stop bit completes

Behaviour:
- One clock; reset is synchronous and active-high (i_clock, i_reset).
- Reset (including mid-frame): on the next edge the state is IDLE, o_tx=1, o_tx_busy=0, o_tx_done=0, and the tick counter, bit counter and shift register are 0. A partial frame is abandoned; the line returns high immediately.
- Registers:
  - state: IDLE, START, DATA, STOP.
  - s_cnt: 0..max(OVERSAMPLE,SB_TICK)-1.
  - n_cnt: 0..NB_DATA-1.
  - shreg: NB_DATA bits.
- IDLE:
  - o_tx=1, busy=0.
  - If i_tx_start=1: shreg<=i_tx_data, s_cnt<=0, go to START.
  - Start is level-sampled. If held high, a new frame begins on the cycle after return to IDLE.
- START:
  - o_tx=0.
  - On each i_tick, s_cnt increments.
  - On i_tick with s_cnt==OVERSAMPLE-1: s_cnt<=0, n_cnt<=0, go to DATA.
- DATA:
  - o_tx=shreg[0].
  - On i_tick with s_cnt==OVERSAMPLE-1: s_cnt<=0 and shreg shifts right by 1.
  - At that point, if n_cnt==NB_DATA-1 go to STOP; otherwise n_cnt++.
- STOP:
  - o_tx=1.
  - On i_tick with s_cnt==SB_TICK-1: go to IDLE and assert o_tx_done for exactly that one cycle.
- No i_tick means no progress: all counters and state hold.
- o_tx is registered and reflects the state of the previous edge. The first low start bit appears one cycle after the accepting edge.
- Frame length is OVERSAMPLE*(1+NB_DATA)+SB_TICK ticks; the default is 160 ticks.
- o_tx_busy=1 in START/DATA/STOP. o_tx_done and busy never overlap with a new acceptance in the same cycle.
- i_tx_start while busy is ignored, with no queuing. i_tx_data changes after acceptance do not affect the frame in flight.
- Start and a simultaneous i_tick in IDLE: the tick is not counted. The start bit gets a full OVERSAMPLE ticks.

Test Plan:
1. Reset, i_tick tied high, no start for 50 cycles -> o_tx=1, busy=0, done=0 throughout.
2. i_tick every cycle; pulse start with data 0x55 -> o_tx is:
   - 0 for 16 cycles,
   - then bits 1,0,1,0,1,0,1,0, each held 16 cycles,
   - then 1 for 16 cycles.
   done pulses once, 160 cycles after the start bit began.
3. i_tick 1-in-4 cycles, data 0xA3 -> the receiving uart_rx model decodes 0xA3. Bit periods are 64 cycles; total busy is 640 cycles.
4. Send 0x0F, then pulse start with 0xFF at the mid-data bit -> only 0x0F transmitted; 0xFF never appears; one done pulse.
5. Assert i_reset during data bit 3 of 0x00 -> o_tx=1 and busy=0 on the next edge, no done. A subsequent 0x81 is sent correctly.
6. Hold start high with data 0x3C across two frames; SB_TICK=32 -> two back-to-back frames. The stop bit is 32 ticks, and the start bit follows one cycle after the done pulse.
